// File: rtl/func_channel_buffer_pkg.sv
// Shared types and the per-word transfer function for func_channel_buffer.
// The function works on a wide container so one definition serves any DATA_W below FN_W.
package func_channel_buffer_types;

  typedef enum logic [1:0] {
    FM_PASS   = 2'd0,
    FM_ABS    = 2'd1,
    FM_CLAMP0 = 2'd2,
    FM_ADDSAT = 2'd3
  } func_mode_t;

  localparam int SAT_CNT_W = 16;
  localparam int FN_W      = 64;

  // value must arrive sign-extended to FN_W; width is the real data width.
  // Returns {altered, result}, where result is zero-extended beyond width.
  function automatic logic [FN_W:0] apply_func(input func_mode_t  mode,
                                               input logic [FN_W-1:0] value,
                                               input logic [FN_W-1:0] offset,
                                               input int unsigned     width);
    logic [FN_W:0]   mask;
    logic [FN_W-1:0] uval;
    logic [FN_W:0]   sum;
    logic            neg;
    logic            altered;
    logic [FN_W-1:0] result;
    mask    = ({{FN_W{1'b0}}, 1'b1} << width) - {{FN_W{1'b0}}, 1'b1};
    neg     = value[FN_W-1];
    uval    = value & mask[FN_W-1:0];
    sum     = {1'b0, uval} + {1'b0, offset & mask[FN_W-1:0]};
    altered = 1'b0;
    result  = uval;
    case (mode)
      FM_PASS: begin
        altered = 1'b0;
        result  = uval;
      end
      FM_ABS: begin
        altered = 1'b0;
        result  = neg ? ((~value + {{(FN_W-1){1'b0}}, 1'b1}) & mask[FN_W-1:0]) : uval;
      end
      FM_CLAMP0: begin
        altered = neg;
        result  = neg ? {FN_W{1'b0}} : uval;
      end
      FM_ADDSAT: begin
        altered = (sum > mask);
        result  = altered ? mask[FN_W-1:0] : sum[FN_W-1:0];
      end
      default: begin
        altered = 1'b0;
        result  = uval;
      end
    endcase
    return {altered, result};
  endfunction

endpackage

// File: rtl/func_channel_buffer_if.sv
// Blocking-channel bundle: signed producer side (b_in) and unsigned consumer side (b_out).
interface func_channel_buffer_if #(
  parameter int DATA_W = 32
) ();

  logic signed [DATA_W-1:0] b_in;
  logic                     b_in_sync;
  logic                     b_in_notify;
  logic        [DATA_W-1:0] b_out;
  logic                     b_out_sync;
  logic                     b_out_notify;

  modport master (
    output b_in, b_in_sync, b_out_sync,
    input  b_in_notify, b_out, b_out_notify
  );

  modport slave (
    input  b_in, b_in_sync, b_out_sync,
    output b_in_notify, b_out, b_out_notify
  );

endinterface

// File: rtl/func_channel_buffer_fifo.sv
// DEPTH-entry FIFO with a separate occupancy counter and notify flags
// registered from next-state occupancy.
module fc_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic                     not_full,
  output logic                     not_empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [LVL_W-1:0]  level_r;
  logic [LVL_W-1:0]  level_next_s;
  logic              not_full_r;
  logic              not_empty_r;
  logic              push_s;
  logic              pop_s;

  assign push_s = push & not_full_r;
  assign pop_s  = pop & not_empty_r;

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    level_next_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_next_s = level_r + {{(LVL_W-1){1'b0}}, 1'b1};
      2'b01:   level_next_s = level_r - {{(LVL_W-1){1'b0}}, 1'b1};
      default: level_next_s = level_r;
    endcase
  end

  // Storage write port; cleared on reset so the head reads zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers, occupancy and registered notify flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      level_r     <= '0;
      not_full_r  <= 1'b1;
      not_empty_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      level_r     <= level_next_s;
      not_full_r  <= (level_next_s < LVL_W'(DEPTH));
      not_empty_r <= (level_next_s != '0);
    end
  end

  assign rdata     = mem_r[rd_ptr_r];
  assign not_full  = not_full_r;
  assign not_empty = not_empty_r;
  assign level     = level_r;

endmodule

// File: rtl/func_channel_buffer.sv
// Applies a compile-time function to each accepted signed word and buffers the
// unsigned results between two blocking channels; counts altered words.
module func_channel_buffer
  import func_channel_buffer_types::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 4,
  parameter func_mode_t  FUNC_MODE = FM_PASS,
  parameter int unsigned OFFSET    = 32'd1
) (
  input  logic                     clk,
  input  logic                     rst,
  func_channel_buffer_if.slave     ch,
  output logic [SAT_CNT_W-1:0]     sat_count,
  output logic [$clog2(DEPTH):0]   level
);

  logic [FN_W-1:0]      in_ext_s;
  logic [FN_W:0]        fn_s;
  logic                 altered_s;
  logic [DATA_W-1:0]    result_s;
  logic [FN_W-1:0]      fn_unused_s;
  logic                 push_ok_s;
  logic [SAT_CNT_W-1:0] sat_count_r;

  assign in_ext_s    = {{(FN_W-DATA_W){ch.b_in[DATA_W-1]}}, ch.b_in};
  assign fn_s        = apply_func(FUNC_MODE, in_ext_s, FN_W'(OFFSET), DATA_W);
  assign altered_s   = fn_s[FN_W];
  assign result_s    = fn_s[DATA_W-1:0];
  assign fn_unused_s = fn_s[FN_W-1:0];
  assign push_ok_s   = ch.b_in_sync & ch.b_in_notify;

  fc_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ch.b_in_sync),
    .wdata     (result_s),
    .pop       (ch.b_out_sync),
    .rdata     (ch.b_out),
    .not_full  (ch.b_in_notify),
    .not_empty (ch.b_out_notify),
    .level     (level)
  );

  // Saturating count of words changed by clamp or saturation at enqueue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_count_r <= '0;
    end else if (push_ok_s && altered_s && (sat_count_r != {SAT_CNT_W{1'b1}})) begin
      sat_count_r <= sat_count_r + {{(SAT_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      sat_count_r <= sat_count_r;
    end
  end

  assign sat_count = sat_count_r;

endmodule

// File: doc/func_channel_buffer.md
Name: func_channel_buffer

Overview:
- Parametrised successor to the single-value blocking-channel skeleton.
- Accepts signed words on a blocking input channel (b_in) and applies a compile-time-selected function to each word.
- Buffers results in a DEPTH-entry FIFO and emits them as unsigned words on a blocking output channel (b_out).
- Sits between two generated blocking-channel modules and decouples their timing.

Parameters:
- DATA_W, 32, width of b_in (signed) and b_out (unsigned).
- DEPTH, 4, FIFO entries; power of two, at least 2.
- FUNC_MODE, FM_PASS, function applied at enqueue: FM_PASS, FM_ABS, FM_CLAMP0 or FM_ADDSAT.
- OFFSET, 1, unsigned constant added in FM_ADDSAT.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- b_in  input  DATA_W  signed input value.
- b_in_sync  input  1  producer offers b_in this cycle.
- b_in_notify  output  1  block can accept a value.
- b_out  output  DATA_W  unsigned output value (FIFO head).
- b_out_sync  input  1  consumer takes b_out this cycle.
- b_out_notify  output  1  b_out holds valid data.
- sat_count  output  16  number of words altered by clamp or saturation; sticks at 0xFFFF.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - b_in_notify=1, b_out_notify=0, b_out=0, sat_count=0, level=0.
  - Pointers cleared.
  - Entering reset mid-transfer discards all buffered data; no partial transfer survives.
- Transfers:
  - Input transfer occurs on the edge where b_in_sync=1 and b_in_notify=1.
  - Output transfer occurs on the edge where b_out_sync=1 and b_out_notify=1.
  - sync without notify has no effect, and the producer/consumer holds its value.
- Notify timing:
  - Both notifies are registered from the next-state occupancy: b_in_notify <= (level_next < DEPTH); b_out_notify <= (level_next > 0).
  - Registered notifies are never combinationally dependent on sync.
- Latency:
  - A word accepted at edge t into an empty FIFO is at b_out with b_out_notify=1 after edge t.
  - It can be consumed at edge t+1.
  - Throughput is one word per cycle in steady state.
- b_out always equals the FIFO head. Its value when b_out_notify=0 is don't-care, but b_out must not change while b_out_notify=1 and no pop occurs.
- Simultaneous push and pop: level unchanged, both transfers happen; allowed when 0<level<DEPTH.
- When full, b_in_notify=0 and no push is possible; a pop at level DEPTH raises b_in_notify on the following cycle.
- When empty, b_out_notify=0 and no pop is possible.
- Functions (evaluated at push, result stored DATA_W unsigned):
  - FM_PASS: bit copy of b_in.
  - FM_ABS: |b_in|; the most negative value maps to 2^(DATA_W-1).
  - FM_CLAMP0: negative values become 0 (counted as a saturation event); others are copied.
  - FM_ADDSAT: unsigned(b_in)+OFFSET computed in DATA_W+1 bits; on carry the result is 2^DATA_W-1 (counted).
- sat_count increments by 1 per altered pushed word and saturates at 0xFFFF.
- Pointers wrap modulo DEPTH; occupancy is tracked with a separate counter (level) so full and empty are unambiguous.

Decomposition:
- Package func_channel_buffer_types holds:
  - func_mode_t enum {FM_PASS, FM_ABS, FM_CLAMP0, FM_ADDSAT}, 2 bits.
  - Localparam SAT_CNT_W=16.
  - A function apply_func(mode, value, offset) returning {altered, result}, shared with the bench reference model.
- Sub-module fc_fifo(DATA_W, DEPTH) contains:
  - Storage, read/write pointers, level counter.
  - Registered not-full and not-empty flags.
- The top contains the function stage, sat_count, and channel port mapping.

Test Plan:
- Reset then idle: rst low then high, no sync → b_in_notify=1, b_out_notify=0, level=0, sat_count=0 for 10 cycles.
- FM_PASS, DATA_W=32, DEPTH=4: push 5, 6, 7, 8 with b_out_sync=0 → level=4, b_in_notify=0 from the cycle after the 4th push; a 5th offer (9) is ignored. Then b_out_sync=1 → outputs 5, 6, 7, 8 in order, after which b_out_notify=0.
- Streaming: b_in_sync and b_out_sync held high, push 0..99 → every value out in order, level never exceeds 1, one word per cycle after the first.
- FM_CLAMP0: push -3, 4, -2147483648 → outputs 0, 4, 0 and sat_count=2. FM_ABS with -2147483648 → output 0x80000000.
- FM_ADDSAT, OFFSET=1: push 0xFFFFFFFE, 0xFFFFFFFF → outputs 0xFFFFFFFF, 0xFFFFFFFF, sat_count=1.
- Reset mid-operation: with level=3, drive rst=0 asynchronously between edges → b_out_notify=0, b_in_notify=1, level=0 immediately. After release, first push 42 → first output 42.
